// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares the single write port of one async FIFO
// between NUM_REQ valid/ready requesters in the write-clock domain. One
// requester owns the port for a burst of at most MAX_BURST beats. The
// arbiter backs off when the FIFO reports full (stall) or almost-full (end
// the burst after the current beat).
//
// Ports:
//   i_clk          write-domain clock (same as FIFO wr_clk)
//   i_rst          synchronous reset, active-high
//   i_req_valid    per-requester data valid
//   i_req_data     requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready    per-requester accept (only the owner, only while not full)
//   o_fifo_wr_en   FIFO write enable (equals the beat-accepted term)
//   o_fifo_wr_data FIFO write data (owner's slice, always steered)
//   i_fifo_full    FIFO full flag (registered in the FIFO)
//   i_fifo_afull   FIFO almost-full flag (registered in the FIFO)
//   o_grant        one-hot owner of the current burst, zero in IDLE
//   o_busy         high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
  input  logic                          i_fifo_full,
  input  logic                          i_fifo_afull,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_gnt_idx;
  logic [IDX_W-1:0]     w_gnt_idx_nxt;
  logic [IDX_W-1:0]     r_last_idx;
  logic [IDX_W-1:0]     w_last_idx_nxt;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [CNT_W-1:0]     w_beat_cnt_nxt;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   w_grant_nxt;

  logic [NUM_REQ-1:0]   w_above_mask;
  logic [NUM_REQ-1:0]   w_valid_hi;
  logic [NUM_REQ-1:0]   w_valid_lo;
  logic [IDX_W-1:0]     w_idx_hi;
  logic [IDX_W-1:0]     w_idx_lo;
  logic [IDX_W-1:0]     w_winner_idx;
  logic                 w_gnt_valid;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                 w_in_burst;
  logic                 w_beat_acc;
  logic                 w_burst_end;

  // Round-robin winner: lowest valid index above last_idx, else lowest valid
  // index at or below it. This is the cyclic search starting at last_idx+1.
  always_comb begin
    w_above_mask = '0;
    w_idx_hi     = '0;
    w_idx_lo     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_above_mask[i] = (IDX_W'(i) > r_last_idx);
    end
    w_valid_hi = i_req_valid & w_above_mask;
    w_valid_lo = i_req_valid & ~w_above_mask;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx_hi = w_valid_hi[i] ? IDX_W'(i) : w_idx_hi;
      w_idx_lo = w_valid_lo[i] ? IDX_W'(i) : w_idx_lo;
    end
    w_winner_idx = (|w_valid_hi) ? w_idx_hi : w_idx_lo;
  end

  // Steer the owner's valid bit and data word (AND-OR mux on gnt_idx).
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_valid = w_gnt_valid | ((r_gnt_idx == IDX_W'(i)) & i_req_valid[i]);
      w_gnt_data  = w_gnt_data |
                    ({DATA_WIDTH{r_gnt_idx == IDX_W'(i)}} &
                     i_req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Ready is also masked by reset so a beat in the reset cycle is not taken.
  assign w_in_burst  = (r_state == ST_BURST);
  assign w_beat_acc  = w_in_burst & w_gnt_valid & ~i_fifo_full & ~i_rst;
  assign w_burst_end = (w_beat_acc &
                        ((r_beat_cnt == CNT_W'(MAX_BURST - 1)) | i_fifo_afull)) |
                       ~w_gnt_valid;

  assign o_req_ready    = (w_in_burst & ~i_fifo_full & ~i_rst) ? r_grant : '0;
  assign o_fifo_wr_en   = w_beat_acc;
  assign o_fifo_wr_data = w_gnt_data;
  assign o_grant        = r_grant;
  assign o_busy         = w_in_burst;

  // Next-state logic: arbitration in IDLE, beat counting and exit in BURST.
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_idx_nxt = r_last_idx;
    w_beat_cnt_nxt = r_beat_cnt;
    w_grant_nxt    = r_grant;
    case (r_state)
      ST_IDLE: begin
        if ((|i_req_valid) && !i_fifo_full && !i_fifo_afull) begin
          w_state_nxt    = ST_BURST;
          w_gnt_idx_nxt  = w_winner_idx;
          w_last_idx_nxt = w_winner_idx;
          w_beat_cnt_nxt = '0;
          w_grant_nxt    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner_idx;
        end else begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end
      end
      ST_BURST: begin
        if (w_beat_acc) begin
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end else begin
          w_beat_cnt_nxt = r_beat_cnt;
        end
        // A full stall with valid held never ends the burst.
        if (w_burst_end) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and arbitration registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_gnt_idx  <= '0;
      r_last_idx <= IDX_W'(NUM_REQ - 1);
      r_beat_cnt <= '0;
      r_grant    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_grant    <= w_grant_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter. A behavioural model tracks who
// owns the port and how many beats remain, and a monitor compares every
// output each cycle. Scenario tasks add targeted inline checks. Requester i
// presents the word (seq_i + 4*i) and advances seq_i on each accepted beat,
// so data order and loss are visible.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 4;
  localparam int MAX_BURST  = 4;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model state
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = NUM_REQ - 1;
  int m_count = 0;
  int m_seq [NUM_REQ];

  logic [NUM_REQ-1:0]    exp_grant;
  logic [NUM_REQ-1:0]    exp_ready;
  logic                  exp_wr_en;
  logic [DATA_WIDTH-1:0] exp_data;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .o_fifo_wr_en  (fifo_wr_en),
    .o_fifo_wr_data(fifo_wr_data),
    .i_fifo_full   (fifo_full),
    .i_fifo_afull  (fifo_afull),
    .o_grant       (grant),
    .o_busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) m_seq[i] = 0;
  end

  // Requester data words derived from each requester's sequence number.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(m_seq[i] + 4 * i);
  end

  // Expected outputs from the model state and the current inputs.
  always_comb begin
    exp_grant = m_busy ? (NUM_REQ'(1) << m_owner) : '0;
    exp_wr_en = m_busy && req_valid[m_owner] && !fifo_full && !rst;
    exp_ready = (m_busy && !fifo_full && !rst) ? exp_grant : '0;
    exp_data  = DATA_WIDTH'(m_seq[m_owner] + 4 * m_owner);
  end

  // Model update at each clock edge.
  always @(posedge clk) begin
    bit acc;
    bit fin;
    int w;
    bit found;
    acc = exp_wr_en;
    if (rst) begin
      m_busy  = 1'b0;
      m_last  = NUM_REQ - 1;
      m_count = 0;
    end else if (!m_busy) begin
      if ((|req_valid) && !fifo_full && !fifo_afull) begin
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
          if (!found && req_valid[(m_last + k) % NUM_REQ]) begin
            w = (m_last + k) % NUM_REQ;
            found = 1'b1;
          end
        end
        m_owner = w;
        m_last  = w;
        m_count = 0;
        m_busy  = 1'b1;
      end
    end else begin
      fin = (acc && ((m_count == MAX_BURST - 1) || fifo_afull)) || !req_valid[m_owner];
      if (acc) begin
        m_seq[m_owner] = m_seq[m_owner] + 1;
        m_count = m_count + 1;
      end
      if (fin) m_busy = 1'b0;
    end
  end

  // Cycle monitor: all outputs against the model, away from the clock edge.
  always @(negedge clk) begin
    if (mon_en) begin
      checks = checks + 4;
      if (grant !== exp_grant) begin
        failures++;
        $display("FAIL mon_grant t=%0t actual=%b required=%b", $time, grant, exp_grant);
      end
      if (busy !== m_busy) begin
        failures++;
        $display("FAIL mon_busy t=%0t actual=%b required=%b", $time, busy, m_busy);
      end
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL mon_ready t=%0t actual=%b required=%b", $time, req_ready, exp_ready);
      end
      if (fifo_wr_en !== exp_wr_en) begin
        failures++;
        $display("FAIL mon_wr_en t=%0t actual=%b required=%b", $time, fifo_wr_en, exp_wr_en);
      end
      if (exp_wr_en) begin
        checks++;
        if (fifo_wr_data !== exp_data) begin
          failures++;
          $display("FAIL mon_wr_data t=%0t actual=%h required=%h", $time, fifo_wr_data, exp_data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '1; fifo_full = 1'b0; fifo_afull = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (grant !== '0 || fifo_wr_en !== 1'b0 || req_ready !== '0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d actual grant=%b wr_en=%b ready=%b required 0,0,0",
                 c, grant, fifo_wr_en, req_ready);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle actual=%b required=0000", grant);
    end
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant actual=%b required=0001", grant);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int cnt[NUM_REQ];
    int run;
    int total;
    int mx;
    int mn;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [NUM_REQ-1:0] prev;
    do_reset();
    req_valid = '1;
    prev = '0; run = 0; total = 0;
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (grant != '0 && prev == '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) order.push_back(i);
      end
      if (fifo_wr_en) begin
        run++; total++;
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) cnt[i]++;
      end else if (run != 0) begin
        checks++;
        if (run != MAX_BURST) begin
          failures++;
          $display("FAIL rr_burst_len actual=%0d required=%0d", run, MAX_BURST);
        end
        run = 0;
      end
      prev = grant;
      tick();
    end
    checks++;
    if (run != MAX_BURST) begin
      failures++;
      $display("FAIL rr_last_burst_len actual=%0d required=%0d", run, MAX_BURST);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= order.size() || order[k] != exp_order[k]) begin
        failures++;
        $display("FAIL rr_order idx=%0d actual=%0d required=%0d", k,
                 (k < order.size()) ? order[k] : -1, exp_order[k]);
      end
    end
    mx = cnt[0]; mn = cnt[0];
    for (int i = 1; i < NUM_REQ; i++) begin
      if (cnt[i] > mx) mx = cnt[i];
      if (cnt[i] < mn) mn = cnt[i];
    end
    checks++;
    if (mx - mn > 4) begin
      failures++;
      $display("FAIL rr_fairness actual_spread=%0d required<=4", mx - mn);
    end
    checks++;
    if (total != 32) begin
      failures++;
      $display("FAIL rr_total_writes actual=%0d required=32", total);
    end
  endtask

  task automatic test_early_release();
    int writes;
    do_reset();
    req_valid = 4'b0100;
    writes = 0;
    tick();
    for (int c = 0; c < 2; c++) begin
      if (fifo_wr_en) writes++;
      tick();
    end
    req_valid = 4'b0000;
    #1;
    if (fifo_wr_en) writes++;
    checks++;
    if (writes != 2) begin
      failures++;
      $display("FAIL early_writes actual=%0d required=2", writes);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL early_idle actual=%b required=0", busy);
    end
    req_valid = 4'b1011;
    tick();
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL early_next_grant actual=%b required=1000", grant);
    end
  endtask

  task automatic test_full_stall();
    logic [DATA_WIDTH-1:0] d0;
    do_reset();
    req_valid = 4'b0001;
    tick();
    d0 = DATA_WIDTH'(m_seq[0]);
    checks++;
    if (fifo_wr_en !== 1'b1 || fifo_wr_data !== d0) begin
      failures++;
      $display("FAIL stall_beat0 actual wr_en=%b data=%h required 1,%h", fifo_wr_en, fifo_wr_data, d0);
    end
    tick();
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== '0 || grant !== 4'b0001) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d actual wr_en=%b ready=%b grant=%b required 0,0000,0001",
                 c, fifo_wr_en, req_ready, grant);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_wr_data !== DATA_WIDTH'(d0 + k)) begin
        failures++;
        $display("FAIL stall_resume beat=%0d actual wr_en=%b data=%h required 1,%h",
                 k, fifo_wr_en, fifo_wr_data, DATA_WIDTH'(d0 + k));
      end
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_end actual=%b required=0", busy);
    end
  endtask

  task automatic test_afull();
    do_reset();
    req_valid = 4'b0001;
    tick();
    tick();
    fifo_afull = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b1) begin
      failures++;
      $display("FAIL afull_beat1 actual=%b required=1", fifo_wr_en);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL afull_exit actual=%b required=0", busy);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (grant !== '0) begin
        failures++;
        $display("FAIL afull_no_grant cycle=%0d actual=%b required=0000", c, grant);
      end
    end
    fifo_afull = 1'b0;
    req_valid = 4'b0011;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL afull_regrant actual=%b required=0010", grant);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0010;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (fifo_wr_en !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL midrst_gate actual wr_en=%b ready=%b required 0,0000", fifo_wr_en, req_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL midrst_state actual grant=%b busy=%b wr_en=%b ready=%b required all 0",
               grant, busy, fifo_wr_en, req_ready);
    end
    req_valid = '1;
    tick();
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL midrst_priority actual=%b required=0001", grant);
    end
  endtask

  task automatic test_random();
    int dut_writes;
    int seq_before;
    int seq_after;
    do_reset();
    dut_writes = 0;
    seq_before = 0;
    for (int i = 0; i < NUM_REQ; i++) seq_before += m_seq[i];
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      fifo_full  = ($urandom_range(0, 7) == 0);
      fifo_afull = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
      #1;
      if (fifo_wr_en) dut_writes++;
      tick();
    end
    rst = 1'b0;
    seq_after = 0;
    for (int i = 0; i < NUM_REQ; i++) seq_after += m_seq[i];
    checks++;
    if (dut_writes != seq_after - seq_before) begin
      failures++;
      $display("FAIL random_write_count actual=%0d required=%0d", dut_writes, seq_after - seq_before);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    tick();
    mon_en = 1'b1;
    test_reset();
    test_round_robin();
    test_early_release();
    test_full_stall();
    test_afull();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of one `async_fifo` instance between `NUM_REQ` requesters in the write-clock domain. Each requester holds a valid/ready stream. The arbiter grants one requester at a time for a bounded burst, steers its data onto the FIFO write port, and backs off on `full`/`afull`. It sits directly in front of the FIFO's `wr_en`/`wr_data` inputs; the FIFO's `full` and `afull` outputs feed back into it.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..16.
- `DATA_WIDTH`, 4: word width; must equal the FIFO's `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum beats per grant; legal range 1..256.

Ports. One clock; reset is synchronous and active-high.
- `clk`, in, 1: write-domain clock, same clock as the FIFO's `wr_clk`.
- `rst`, in, 1: synchronous reset, active-high.
- `req_valid`, in, NUM_REQ: per-requester data valid.
- `req_data`, in, NUM_REQ*DATA_WIDTH: requester i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`, out, NUM_REQ: per-requester accept.
- `fifo_wr_en`, out, 1: drives FIFO `wr_en`.
- `fifo_wr_data`, out, DATA_WIDTH: drives FIFO `wr_data`.
- `fifo_full`, in, 1: from FIFO `full`.
- `fifo_afull`, in, 1: from FIFO `afull`.
- `grant`, out, NUM_REQ: one-hot owner of the current burst; all zero in IDLE.
- `busy`, out, 1: high while in BURST.

## Operation

- The FSM has two states: IDLE and BURST. There is a registered `gnt_idx` and a registered `last_idx` (the most recently granted requester). Reset value of `last_idx` is NUM_REQ-1, so requester 0 has first priority.
- IDLE to BURST: taken when any `req_valid` is high and `fifo_full`=0 and `fifo_afull`=0.
  - The winner is the first requester with `req_valid` high, searching cyclically from `last_idx`+1 (mod NUM_REQ).
  - On the transition, `gnt_idx` and `last_idx` load the winner and the beat counter clears to 0.
- In BURST:
  - `req_ready[gnt_idx]` = !`fifo_full`; every other `req_ready` bit is 0.
  - A beat is accepted when `req_valid[gnt_idx]` && `req_ready[gnt_idx]`.
  - `fifo_wr_en` equals the beat-accepted term. `fifo_wr_data` = the `req_data` slice of `gnt_idx`.
  - Each accepted beat increments the beat counter (width clog2(MAX_BURST)+1).
- BURST to IDLE: taken at the end of a cycle in which any of the following holds:
  - a beat is accepted with counter == MAX_BURST-1;
  - a beat is accepted while `fifo_afull`=1;
  - `req_valid[gnt_idx]`=0 (the requester released the bus).
- `fifo_full`=1 in BURST stalls: ready stays low, the state is held, and the counter is held. A stall alone never ends a burst.
- `fifo_wr_en` and `req_ready` are never high in IDLE. `fifo_wr_data` is don't-care when `fifo_wr_en`=0 and is driven with the `gnt_idx` slice in all states.
- Data path is pure combinational steering: no word is buffered, dropped or duplicated. Every accepted beat produces exactly one FIFO write in the same cycle.

## Timing

- Reset values: state=IDLE, `grant`=0, `busy`=0, `req_ready`=0, `fifo_wr_en`=0, beat counter=0, `last_idx`=NUM_REQ-1.
- `rst` high overrides everything at the next edge, including mid-burst. A beat presented in the reset cycle is not accepted, because ready is forced to 0 while `rst` is high.
- Arbitration latency: `req_valid` seen in IDLE at edge N gives `grant`/`busy` high after edge N, and the first beat can be accepted in cycle N+1. This is one dead cycle per grant.
- Burst end: the IDLE cycle following a burst is mandatory, so back-to-back bursts are spaced by at least one idle cycle.
- `fifo_full`/`fifo_afull` are sampled combinationally in the same cycle. Both are registered outputs of the FIFO, so there is no combinational loop.
- Simultaneous events:
  - If the burst-limit beat and `fifo_afull` coincide, the FSM exits once; neither condition takes precedence.
  - If valid drops in the same cycle as a stall, the FSM exits.
- Throughput: a sustained single requester reaches MAX_BURST/(MAX_BURST+1) of the write bandwidth.

## Test plan

- Reset: hold `rst` for 3 cycles with all `req_valid`=1. Expect `grant`=0, `fifo_wr_en`=0 and `req_ready`=0 throughout. The first grant after release goes to requester 0.
- Round-robin fairness: NUM_REQ=4, MAX_BURST=4, all requesters continuously valid. Expect grants in order 0,1,2,3,0, each burst exactly 4 writes, with 1 idle cycle between bursts. After 40 cycles, write counts per requester differ by at most 4.
- Early release: requester 2 sole valid for 2 beats, then valid low. Expect exactly 2 writes, then IDLE. The next grant goes to the first valid requester after index 2.
- Full stall: `fifo_full` forced to 1 for 5 cycles mid-burst at beat 1. Expect `fifo_wr_en`=0 and `req_ready`=0 for 5 cycles, `grant` unchanged, then the remaining 3 beats written in order with no data loss.
- Almost-full back-off: `fifo_afull` rises at beat 1 of 4. Expect the burst to end after that beat (2 writes total). No new grant is issued while `fifo_afull`=1.
- Reset mid-burst: assert `rst` at beat 2. Expect all outputs at reset values the next cycle and the priority pointer restored to requester 0.
